// File: rtl/controle_partida_if.sv
// Map memory port of the match sequencer: shared address/write data,
// per-map write enables and per-map read data (valid one cycle after address).
interface controle_partida_if;
    logic       mem1_we;
    logic       mem2_we;
    logic [5:0] mem_addr;
    logic [1:0] mem_wdata;
    logic [1:0] mem1_rdata;
    logic [1:0] mem2_rdata;

    modport master (
        output mem1_we, mem2_we, mem_addr, mem_wdata,
        input  mem1_rdata, mem2_rdata
    );

    modport slave (
        input  mem1_we, mem2_we, mem_addr, mem_wdata,
        output mem1_rdata, mem2_rdata
    );
endinterface

// File: rtl/controle_partida.sv
// Naval-battle match sequencer: placement routing, shot arbitration, score and winner.
// Optional turn timeout enabled by defining TIMEOUT_TURNO_EN.
module controle_partida #(
    parameter int unsigned ACERTOS_VITORIA = 10
`ifdef TIMEOUT_TURNO_EN
    , parameter int unsigned TIMEOUT_CICLOS = 1000
`endif
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       on,
    input  logic                       mode,
    input  logic                       pos_start,
    input  logic                       pos_we,
    input  logic [5:0]                 pos_addr,
    input  logic [1:0]                 pos_data,
    input  logic                       tiro_valida,
    input  logic [2:0]                 tiro_x,
    input  logic [2:0]                 tiro_y,
    controle_partida_if.master         mem,
    output logic                       pos_on,
    output logic                       pos_reinicia,
    output logic                       jog_on,
    output logic                       jogador,
    output logic                       tiro_pronto,
    output logic                       acertou_tiro,
    output logic                       repetido,
    output logic                       fim,
    output logic                       vencedor
);

    localparam int unsigned CNT_W = 7;
    localparam int unsigned TO_W  = 32;

    localparam logic [1:0] AGUA           = 2'b00;
    localparam logic [1:0] NAVIO          = 2'b01;
    localparam logic [1:0] NAVIO_ATINGIDO = 2'b10;
    localparam logic [1:0] AGUA_ATINGIDA  = 2'b11;

    typedef enum logic [2:0] {
        DESL, POS_J1, POS_J2, ESPERA, TIRO_LE, TIRO_AVALIA, FIM
    } estado_t;

    estado_t            estado;
    logic [CNT_W-1:0]   acertos_j1;
    logic [CNT_W-1:0]   acertos_j2;
    logic [CNT_W-1:0]   acertos_prox;
    logic [1:0]         dado_oponente;
`ifdef TIMEOUT_TURNO_EN
    logic [TO_W-1:0]    to_cnt;
`endif

    // J1 (jogador=0) shoots at map 2, J2 at map 1
    assign dado_oponente = jogador ? mem.mem1_rdata : mem.mem2_rdata;
    assign acertos_prox  = (jogador ? acertos_j2 : acertos_j1) + CNT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado        <= DESL;
            acertos_j1    <= '0;
            acertos_j2    <= '0;
            mem.mem1_we   <= 1'b0;
            mem.mem2_we   <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            pos_on        <= 1'b0;
            pos_reinicia  <= 1'b0;
            jog_on        <= 1'b0;
            jogador       <= 1'b0;
            tiro_pronto   <= 1'b0;
            acertou_tiro  <= 1'b0;
            repetido      <= 1'b0;
            fim           <= 1'b0;
            vencedor      <= 1'b0;
`ifdef TIMEOUT_TURNO_EN
            to_cnt        <= '0;
`endif
        end else begin
            // Strobes default low every cycle
            mem.mem1_we   <= 1'b0;
            mem.mem2_we   <= 1'b0;
            pos_reinicia  <= 1'b0;
            tiro_pronto   <= 1'b0;
            acertou_tiro  <= 1'b0;
            repetido      <= 1'b0;
`ifdef TIMEOUT_TURNO_EN
            to_cnt        <= '0;
`endif
            if (!on) begin
                estado        <= DESL;
                acertos_j1    <= '0;
                acertos_j2    <= '0;
                mem.mem_addr  <= '0;
                mem.mem_wdata <= '0;
                pos_on        <= 1'b0;
                jog_on        <= 1'b0;
                jogador       <= 1'b0;
                fim           <= 1'b0;
                vencedor      <= 1'b0;
            end else begin
                case (estado)
                    DESL: begin
                        estado <= POS_J1;
                        pos_on <= 1'b1;
                    end
                    POS_J1: begin
                        mem.mem1_we   <= pos_we;
                        mem.mem_addr  <= pos_addr;
                        mem.mem_wdata <= pos_data;
                        if (pos_start) begin
                            estado       <= POS_J2;
                            pos_reinicia <= 1'b1;
                        end
                    end
                    POS_J2: begin
                        mem.mem2_we   <= pos_we;
                        mem.mem_addr  <= pos_addr;
                        mem.mem_wdata <= pos_data;
                        if (pos_start) begin
                            estado  <= ESPERA;
                            jogador <= mode;
                            pos_on  <= 1'b0;
                            jog_on  <= 1'b1;
                        end
                    end
                    ESPERA: begin
                        if (tiro_valida) begin
                            mem.mem_addr <= {tiro_y, tiro_x};
                            estado       <= TIRO_LE;
                        end
`ifdef TIMEOUT_TURNO_EN
                        else if (to_cnt == TO_W'(TIMEOUT_CICLOS - 1)) begin
                            jogador     <= ~jogador;
                            tiro_pronto <= 1'b1;
                        end else begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
`endif
                    end
                    TIRO_LE: begin
                        estado <= TIRO_AVALIA;
                    end
                    TIRO_AVALIA: begin
                        tiro_pronto <= 1'b1;
                        estado      <= ESPERA;
                        case (dado_oponente)
                            NAVIO: begin
                                mem.mem1_we   <= jogador;
                                mem.mem2_we   <= ~jogador;
                                mem.mem_wdata <= NAVIO_ATINGIDO;
                                acertou_tiro  <= 1'b1;
                                if (jogador) acertos_j2 <= acertos_prox;
                                else         acertos_j1 <= acertos_prox;
                                if (acertos_prox == CNT_W'(ACERTOS_VITORIA)) begin
                                    estado <= FIM;
                                    jog_on <= 1'b0;
                                end
                            end
                            AGUA: begin
                                mem.mem1_we   <= jogador;
                                mem.mem2_we   <= ~jogador;
                                mem.mem_wdata <= AGUA_ATINGIDA;
                                jogador       <= ~jogador;
                            end
                            default: begin
                                repetido <= 1'b1;
                            end
                        endcase
                    end
                    FIM: begin
                        // Winner is the shooter: a hit never passes the turn
                        fim      <= 1'b1;
                        vencedor <= jogador;
                        jog_on   <= 1'b0;
                    end
                    default: begin
                        estado <= DESL;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_controle_partida.sv
// Directed bench for controle_partida with two behavioural map memories.
// Exercises the turn timeout too when TIMEOUT_TURNO_EN is defined.
module tb_controle_partida;

    logic       clk;
    logic       reset;
    logic       on;
    logic       mode;
    logic       pos_start;
    logic       pos_we;
    logic [5:0] pos_addr;
    logic [1:0] pos_data;
    logic       tiro_valida;
    logic [2:0] tiro_x;
    logic [2:0] tiro_y;
    logic       pos_on;
    logic       pos_reinicia;
    logic       jog_on;
    logic       jogador;
    logic       tiro_pronto;
    logic       acertou_tiro;
    logic       repetido;
    logic       fim;
    logic       vencedor;

    int checks   = 0;
    int failures = 0;

    logic [1:0] map1 [64];
    logic [1:0] map2 [64];

`ifdef TIMEOUT_TURNO_EN
    localparam int EXP_PULSES = 1;
    localparam logic EXP_JOG_TO = 1'b1;
`else
    localparam int EXP_PULSES = 0;
    localparam logic EXP_JOG_TO = 1'b0;
`endif

    controle_partida_if mif ();

    controle_partida #(
        .ACERTOS_VITORIA (2)
`ifdef TIMEOUT_TURNO_EN
        , .TIMEOUT_CICLOS (8)
`endif
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .on           (on),
        .mode         (mode),
        .pos_start    (pos_start),
        .pos_we       (pos_we),
        .pos_addr     (pos_addr),
        .pos_data     (pos_data),
        .tiro_valida  (tiro_valida),
        .tiro_x       (tiro_x),
        .tiro_y       (tiro_y),
        .mem          (mif),
        .pos_on       (pos_on),
        .pos_reinicia (pos_reinicia),
        .jog_on       (jog_on),
        .jogador      (jogador),
        .tiro_pronto  (tiro_pronto),
        .acertou_tiro (acertou_tiro),
        .repetido     (repetido),
        .fim          (fim),
        .vencedor     (vencedor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read map memories, read-before-write
    initial begin
        for (int i = 0; i < 64; i++) begin
            map1[i] = 2'b00;
            map2[i] = 2'b00;
        end
    end

    always @(posedge clk) begin
        if (mif.mem1_we) map1[mif.mem_addr] <= mif.mem_wdata;
        if (mif.mem2_we) map2[mif.mem_addr] <= mif.mem_wdata;
        mif.mem1_rdata <= map1[mif.mem_addr];
        mif.mem2_rdata <= map2[mif.mem_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic logic [18:0] outs();
        return {pos_on, pos_reinicia, jog_on, jogador, tiro_pronto, acertou_tiro,
                repetido, fim, vencedor, mif.mem1_we, mif.mem2_we, mif.mem_addr, mif.mem_wdata};
    endfunction

    function automatic logic [7:0] shot_res();
        return {tiro_pronto, acertou_tiro, repetido, mif.mem1_we, mif.mem2_we,
                mif.mem_wdata, jogador};
    endfunction

    function automatic logic [5:0] shot_res_nw();
        return {tiro_pronto, acertou_tiro, repetido, mif.mem1_we, mif.mem2_we, jogador};
    endfunction

    // Request a shot and return at the negedge of cycle N+2 (result cycle)
    task automatic shot(input logic [2:0] x, input logic [2:0] y);
        tiro_valida = 1'b1;
        tiro_x      = x;
        tiro_y      = y;
        cyc();
        tiro_valida = 1'b0;
        check("shot_addr", 32'(mif.mem_addr), 32'({y, x}));
        cyc();
        check("pronto_early", 32'(tiro_pronto), 32'(0));
        cyc();
    endtask

    initial begin
        int pulses;
        reset = 1'b0; on = 1'b0; mode = 1'b0;
        pos_start = 1'b0; pos_we = 1'b0; pos_addr = '0; pos_data = '0;
        tiro_valida = 1'b0; tiro_x = '0; tiro_y = '0;

        repeat (2) cyc();
        check("rst_outputs", 32'(outs()), 32'(0));
        reset = 1'b1;
        cyc();
        check("desl_idle", 32'(outs()), 32'(0));

        // Placement: J1 writes ship at 9, J2 writes ships at 10 and 9
        on = 1'b1;
        cyc();
        check("pos_on_j1", 32'({pos_on, jog_on}), 32'(2'b10));
        pos_we = 1'b1; pos_addr = 6'd9; pos_data = 2'b01; pos_start = 1'b1;
        cyc();
        check("j1_we", 32'({mif.mem1_we, mif.mem2_we}), 32'(2'b10));
        check("j1_addr", 32'(mif.mem_addr), 32'(9));
        check("reinicia", 32'(pos_reinicia), 32'(1));
        pos_start = 1'b0; pos_addr = 6'd10;
        cyc();
        check("reinicia_once", 32'(pos_reinicia), 32'(0));
        check("j2_we", 32'({mif.mem1_we, mif.mem2_we}), 32'(2'b01));
        pos_addr = 6'd9; pos_start = 1'b1; mode = 1'b0;
        cyc();
        check("j2_last_we", 32'({mif.mem1_we, mif.mem2_we, mif.mem_addr}), 32'({2'b01, 6'd9}));
        check("espera_on", 32'({pos_on, jog_on, jogador}), 32'(3'b010));
        pos_addr = 6'd5;
        cyc();
        check("pos_ignored", 32'({mif.mem1_we, mif.mem2_we, pos_reinicia}), 32'(0));
        check("maps_placed", 32'({map1[9], map2[9], map2[10], map1[5], map2[5]}), 32'(10'b01_01_01_00_00));
        pos_we = 1'b0; pos_start = 1'b0;

        // Shots
        shot(3'd1, 3'd1);
        check("j1_hit", 32'(shot_res()), 32'(8'b11001_10_0));
        shot(3'd0, 3'd0);
        check("j1_miss", 32'(shot_res()), 32'(8'b10001_11_1));
        shot(3'd1, 3'd1);
        check("j2_hit", 32'(shot_res()), 32'(8'b11010_10_1));
        shot(3'd0, 3'd0);
        check("j2_miss", 32'(shot_res()), 32'(8'b10010_11_0));
        shot(3'd0, 3'd0);
        check("j1_rep_water", 32'(shot_res_nw()), 32'(6'b101000));
        shot(3'd1, 3'd1);
        check("j1_rep_ship", 32'(shot_res_nw()), 32'(6'b101000));
        shot(3'd2, 3'd1);
        check("j1_win_hit", 32'(shot_res()), 32'(8'b11001_10_0));
        check("fim_not_yet", 32'(fim), 32'(0));

        tiro_valida = 1'b1; tiro_x = 3'd3; tiro_y = 3'd3;
        cyc();
        check("fim", 32'({fim, vencedor, jog_on, tiro_pronto}), 32'(4'b1000));
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("fim_hold", 32'({fim, vencedor, tiro_pronto, mif.mem1_we, mif.mem2_we}), 32'(5'b10000));
        end
        check("maps_after", 32'({map1[9], map1[0], map2[9], map2[0], map2[10], map1[27], map2[27]}),
              32'(14'b10_11_10_11_10_00_00));
        tiro_valida = 1'b0; on = 1'b0;
        cyc();
        check("off_from_fim", 32'(outs()), 32'(0));

        // Restart with J2 starting, then drop on during TIRO_LE
        on = 1'b1;
        cyc();
        pos_start = 1'b1; mode = 1'b1;
        cyc();
        cyc();
        pos_start = 1'b0;
        check("restart_j2", 32'({jog_on, jogador, pos_on}), 32'(3'b110));
        tiro_valida = 1'b1; tiro_x = 3'd3; tiro_y = 3'd3;
        cyc();
        tiro_valida = 1'b0; on = 1'b0;
        cyc();
        check("off_in_le", 32'(outs()), 32'(0));
        cyc();
        cyc();
        check("no_write", 32'({map1[27], map2[27]}), 32'(0));

        // Asynchronous reset during placement
        on = 1'b1;
        cyc();
        check("pos_on_again", 32'(pos_on), 32'(1));
        pos_we = 1'b1; pos_addr = 6'd20; pos_data = 2'b01;
        cyc();
        check("mid_we", 32'({mif.mem1_we, mif.mem_addr}), 32'({1'b1, 6'd20}));
        #2 reset = 1'b0;
        #1 check("async_reset", 32'(outs()), 32'(0));
        pos_we = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        check("reset_dropped_write", 32'(map1[20]), 32'(0));

        // Idle in ESPERA: timeout pulse only when the feature is built in
        pos_start = 1'b1; mode = 1'b0;
        cyc();
        cyc();
        pos_start = 1'b0;
        check("to_espera", 32'({jog_on, jogador}), 32'(2'b10));
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (tiro_pronto) begin
                pulses++;
                check("to_no_hit", 32'({acertou_tiro, repetido}), 32'(0));
            end
        end
        check("to_pulses", 32'(pulses), 32'(EXP_PULSES));
        check("to_jogador", 32'(jogador), 32'(EXP_JOG_TO));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
